// File: rtl/mem_access_ctrl.sv
// Load/store sequencer: latches one access, checks alignment, drives the word bus
// with byte enables and replicated data, and waits (bounded) for mem_ack.
module mem_access_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  funct,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [31:0] rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam logic [2:0] F_W  = 3'b000;
  localparam logic [2:0] F_BU = 3'b001;
  localparam logic [2:0] F_B  = 3'b010;
  localparam logic [2:0] F_HU = 3'b011;
  localparam logic [2:0] F_H  = 3'b100;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE, FAULT} state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [1:0]        code_reg, code_next;
  logic [31:0]       rdata_reg, rdata_next;
  logic              we_reg;
  logic [2:0]        funct_reg;
  logic [31:0]       addr_reg, wdata_reg;
  logic              latch_en;
  logic              in_access;
  logic [3:0]        be_full;
  logic [31:0]       wdata_rep;
  logic [31:0]       load_ext;
  logic [7:0]        load_byte;
  logic [15:0]       load_half;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      code_reg  <= 2'b00;
      rdata_reg <= 32'h0;
      we_reg    <= 1'b0;
      funct_reg <= 3'b000;
      addr_reg  <= 32'h0;
      wdata_reg <= 32'h0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      code_reg  <= code_next;
      rdata_reg <= rdata_next;
      if (latch_en) begin
        we_reg    <= we;
        funct_reg <= funct;
        addr_reg  <= addr;
        wdata_reg <= wdata;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    code_next  = code_reg;
    rdata_next = rdata_reg;
    latch_en   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req) begin
          latch_en = 1'b1;
          if (funct > F_H) begin
            state_next = FAULT;
            code_next  = 2'b11;
          end else if (((funct == F_H || funct == F_HU) && addr[0]) ||
                       (funct == F_W && addr[1:0] != 2'b00)) begin
            state_next = FAULT;
            code_next  = 2'b01;
          end else begin
            state_next = ACCESS;
            cnt_next   = '0;
          end
        end
      end
      ACCESS: begin
        // An ack arriving on the final timeout cycle still completes the access.
        if (mem_ack) begin
          state_next = DONE;
          if (!we_reg) rdata_next = load_ext;
        end else begin
          cnt_next = cnt_reg + 1'b1;
          if (TIMEOUT != 0 && cnt_reg == CNT_W'(TIMEOUT - 1)) begin
            state_next = FAULT;
            code_next  = 2'b10;
          end
        end
      end
      DONE:    state_next = IDLE;
      FAULT:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    load_byte = mem_rdata[{addr_reg[1:0], 3'b000} +: 8];
    load_half = mem_rdata[{addr_reg[1], 4'b0000} +: 16];
    be_full   = 4'b0000;
    load_ext  = mem_rdata;
    case (funct_reg)
      F_W:  be_full = 4'b1111;
      F_BU: begin be_full = 4'b0001 << addr_reg[1:0]; load_ext = {24'h0, load_byte}; end
      F_B:  begin be_full = 4'b0001 << addr_reg[1:0]; load_ext = {{24{load_byte[7]}}, load_byte}; end
      F_HU: begin be_full = 4'b0011 << addr_reg[1:0]; load_ext = {16'h0, load_half}; end
      F_H:  begin be_full = 4'b0011 << addr_reg[1:0]; load_ext = {{16{load_half[15]}}, load_half}; end
      default: begin be_full = 4'b0000; load_ext = mem_rdata; end
    endcase
  end

  // Each byte lane picks its source so any enabled lane sees the right store byte.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    always_comb begin
      case (funct_reg)
        F_W:        wdata_rep[8*gi +: 8] = wdata_reg[8*gi +: 8];
        F_BU, F_B:  wdata_rep[8*gi +: 8] = wdata_reg[7:0];
        F_HU, F_H:  wdata_rep[8*gi +: 8] = wdata_reg[8*(gi%2) +: 8];
        default:    wdata_rep[8*gi +: 8] = 8'h00;
      endcase
    end
  end

  assign in_access = (state_reg == ACCESS);
  assign busy      = (state_reg != IDLE);
  assign done      = (state_reg == DONE);
  assign err       = (state_reg == FAULT);
  assign err_code  = err ? code_reg : 2'b00;
  assign rdata     = rdata_reg;
  assign mem_req   = in_access;
  assign mem_we    = in_access & we_reg;
  assign mem_be    = in_access ? be_full : 4'b0000;
  assign mem_addr  = in_access ? {addr_reg[31:2], 2'b00} : 32'h0;
  assign mem_wdata = in_access ? wdata_rep : 32'h0;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed cases plus randomized accesses
// checked against an arithmetic model of byte lanes, replication and extension.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset, req, we, mem_ack;
  logic [2:0]  funct;
  logic [31:0] addr, wdata, mem_rdata;
  logic        busy, done, err, mem_req, mem_we;
  logic [1:0]  err_code;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_be;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_rdata = 32'h0;

  // Transaction observations filled in by run_access.
  logic        o_done, o_err, o_req, o_we;
  logic [1:0]  o_code;
  logic [3:0]  o_be;
  logic [31:0] o_addr, o_wdata;
  int          o_cyc, o_acc;

  mem_access_ctrl #(.TIMEOUT(16), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .funct(funct), .addr(addr),
    .wdata(wdata), .busy(busy), .done(done), .err(err), .err_code(err_code),
    .rdata(rdata), .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  function automatic int access_bytes(input logic [2:0] f);
    if (f == 3'd0) return 4;
    if (f == 3'd1 || f == 3'd2) return 1;
    return 2;
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f, input logic [31:0] a);
    int n = access_bytes(f);
    int off = (n == 4) ? 0 : int'(a % 4);
    return 4'(((1 << n) - 1) << off);
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f, input logic [31:0] d);
    int n = access_bytes(f);
    if (n == 4) return d;
    if (n == 1) return (d % 256) * 32'h01010101;
    return (d % 65536) * 32'h00010001;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f, input logic [31:0] a,
                                             input logic [31:0] word);
    int n = access_bytes(f);
    logic [31:0] v;
    if (n == 4) return word;
    if (n == 1) begin
      v = (word >> (8 * (a % 4))) % 256;
      if (f == 3'd2 && v >= 128) v = v + 32'hFFFFFF00;
    end else begin
      v = (word >> (16 * ((a % 4) / 2))) % 65536;
      if (f == 3'd4 && v >= 32768) v = v + 32'hFFFF0000;
    end
    return v;
  endfunction

  function automatic logic model_misaligned(input logic [2:0] f, input logic [31:0] a);
    int n = access_bytes(f);
    return (a % n) != 0;
  endfunction

  // Drive one request from IDLE; ack on the ack_at-th ACCESS cycle (0 = never).
  task automatic run_access(input logic w, input logic [2:0] f, input logic [31:0] a,
                            input logic [31:0] d, input int ack_at, input logic [31:0] word);
    o_done = 0; o_err = 0; o_req = 0; o_we = 0; o_code = 0;
    o_be = 0; o_addr = 0; o_wdata = 0; o_cyc = 0; o_acc = 0;
    req = 1'b1; we = w; funct = f; addr = a; wdata = d; mem_rdata = word; mem_ack = 1'b0;
    @(posedge clk); #1;
    req = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      if (done) begin o_done = 1; o_cyc = c; break; end
      if (err) begin o_err = 1; o_code = err_code; o_cyc = c; break; end
      mem_ack = 1'b0;
      if (mem_req) begin
        o_req = 1; o_acc++;
        o_be = mem_be; o_addr = mem_addr; o_wdata = mem_wdata; o_we = mem_we;
        if (o_acc == ack_at) mem_ack = 1'b1;
      end
      @(posedge clk); #1;
    end
    mem_ack = 1'b0;
    if (o_done || o_err) begin @(posedge clk); #1; end
    $display("txn we=%0b funct=%03b addr=%08h wdata=%08h done=%0b err=%0b code=%02b cyc=%0d rdata=%08h",
             w, f, a, d, o_done, o_err, o_code, o_cyc, rdata);
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 0; we = 0; funct = 0; addr = 0; wdata = 0; mem_rdata = 0; mem_ack = 0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    total++;
    if ({busy, done, err, err_code, mem_req, mem_we, mem_be} !== 10'b0) begin
      bad++; $display("FAIL reset_ctrl got=%b want=0", {busy, done, err, err_code, mem_req, mem_we, mem_be});
    end
    total++;
    if ({rdata, mem_addr, mem_wdata} !== 96'b0) begin
      bad++; $display("FAIL reset_data got=%h want=0", {rdata, mem_addr, mem_wdata});
    end
    exp_rdata = 32'h0;
  endtask

  task automatic test_lbu();
    run_access(1'b0, 3'b001, 32'h1002, 32'h0, 1, 32'h80FF7F01);
    total++;
    if (!(o_done && o_cyc == 2)) begin bad++; $display("FAIL lbu_latency done=%0b cyc=%0d want cyc=2", o_done, o_cyc); end
    total++;
    if (o_be !== 4'b0100 || o_addr !== 32'h1000) begin
      bad++; $display("FAIL lbu_bus be=%b addr=%h want 0100 00001000", o_be, o_addr);
    end
    total++;
    if (rdata !== 32'h000000FF) begin bad++; $display("FAIL lbu_rdata got=%h want=000000ff", rdata); end
    exp_rdata = 32'h000000FF;
  endtask

  task automatic test_lh();
    run_access(1'b0, 3'b100, 32'h1002, 32'h0, 2, 32'h80FF7F01);
    total++;
    if (rdata !== 32'hFFFF80FF || !o_done) begin
      bad++; $display("FAIL lh_rdata got=%h done=%0b want=ffff80ff", rdata, o_done);
    end
    exp_rdata = 32'hFFFF80FF;
  endtask

  task automatic test_misaligned();
    run_access(1'b0, 3'b000, 32'h1001, 32'h0, 1, 32'h11111111);
    total++;
    if (!(o_err && o_code == 2'b01 && o_cyc == 1)) begin
      bad++; $display("FAIL misaligned err=%0b code=%b cyc=%0d want 1 01 1", o_err, o_code, o_cyc);
    end
    total++;
    if (o_req !== 1'b0 || rdata !== exp_rdata) begin
      bad++; $display("FAIL misaligned_side mem_req=%0b rdata=%h want 0 %h", o_req, rdata, exp_rdata);
    end
  endtask

  task automatic test_store();
    run_access(1'b1, 3'b010, 32'h2003, 32'h12345678, 1, 32'hCAFEF00D);
    total++;
    if (o_addr !== 32'h2000 || o_be !== 4'b1000 || o_wdata !== 32'h78787878 || o_we !== 1'b1) begin
      bad++; $display("FAIL sb_bus addr=%h be=%b wdata=%h we=%0b want 00002000 1000 78787878 1",
                      o_addr, o_be, o_wdata, o_we);
    end
    total++;
    if (!o_done || rdata !== exp_rdata) begin
      bad++; $display("FAIL sb_rdata done=%0b rdata=%h want 1 %h", o_done, rdata, exp_rdata);
    end
  endtask

  task automatic test_reserved();
    run_access(1'b0, 3'b110, 32'h0, 32'h0, 1, 32'h0);
    total++;
    if (!(o_err && o_code == 2'b11 && !o_req)) begin
      bad++; $display("FAIL reserved err=%0b code=%b req=%0b want 1 11 0", o_err, o_code, o_req);
    end
  endtask

  task automatic test_timeout();
    run_access(1'b0, 3'b000, 32'h3000, 32'h0, 0, 32'h0);
    total++;
    if (!(o_err && o_code == 2'b10 && o_acc == 16 && o_cyc == 17)) begin
      bad++; $display("FAIL timeout err=%0b code=%b acc=%0d cyc=%0d want 1 10 16 17", o_err, o_code, o_acc, o_cyc);
    end
    run_access(1'b0, 3'b000, 32'h3000, 32'h0, 16, 32'h0BADF00D);
    total++;
    if (!(o_done && !o_err && o_cyc == 17 && rdata == 32'h0BADF00D)) begin
      bad++; $display("FAIL ack_on_timeout done=%0b err=%0b cyc=%0d rdata=%h want 1 0 17 0badf00d",
                      o_done, o_err, o_cyc, rdata);
    end
    exp_rdata = 32'h0BADF00D;
  endtask

  task automatic test_busy_ignore();
    int n_done = 0;
    int n_err = 0;
    req = 1; we = 0; funct = 3'b000; addr = 32'h3000; wdata = 0; mem_rdata = 32'h5A5AA5A5; mem_ack = 0;
    @(posedge clk); #1;
    for (int c = 1; c <= 12; c++) begin
      req = (c <= 2) ? 1'b1 : 1'b0;
      funct = 3'b110;
      mem_ack = (c == 3) ? 1'b1 : 1'b0;
      if (done) n_done++;
      if (err) n_err++;
      @(posedge clk); #1;
    end
    req = 0; mem_ack = 0;
    $display("txn busy_ignore dones=%0d errs=%0d rdata=%08h", n_done, n_err, rdata);
    total++;
    if (n_done != 1 || n_err != 0 || rdata !== 32'h5A5AA5A5) begin
      bad++; $display("FAIL busy_ignore dones=%0d errs=%0d rdata=%h want 1 0 5a5aa5a5", n_done, n_err, rdata);
    end
    exp_rdata = 32'h5A5AA5A5;
  endtask

  task automatic test_reset_mid_access();
    int n_evt = 0;
    req = 1; we = 0; funct = 3'b000; addr = 32'h4000; mem_rdata = 32'hDEADBEEF; mem_ack = 0;
    @(posedge clk); #1;
    req = 0;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    total++;
    if (mem_req !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL reset_mid mem_req=%0b busy=%0b want 0 0", mem_req, busy);
    end
    mem_ack = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (done || err || busy) n_evt++;
    end
    mem_ack = 1'b0;
    $display("txn reset_mid_access events=%0d rdata=%08h", n_evt, rdata);
    total++;
    if (n_evt != 0 || rdata !== 32'h0) begin
      bad++; $display("FAIL stale_ack events=%0d rdata=%h want 0 00000000", n_evt, rdata);
    end
    exp_rdata = 32'h0;
  endtask

  task automatic test_random();
    logic        w;
    logic [2:0]  f;
    logic [31:0] a, d, word;
    int          ack_at;
    for (int i = 0; i < 40; i++) begin
      w = 1'($urandom_range(0, 1));
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a = a & 32'hFFFFFFFC;
      d = $urandom;
      word = $urandom;
      ack_at = $urandom_range(1, 4);
      run_access(w, f, a, d, ack_at, word);
      total++;
      if (f > 3'd4) begin
        if (!(o_err && o_code == 2'b11 && o_cyc == 1 && !o_req)) begin
          bad++; $display("FAIL rand_reserved i=%0d err=%0b code=%b cyc=%0d", i, o_err, o_code, o_cyc);
        end
      end else if (model_misaligned(f, a)) begin
        if (!(o_err && o_code == 2'b01 && o_cyc == 1 && !o_req)) begin
          bad++; $display("FAIL rand_misaligned i=%0d err=%0b code=%b cyc=%0d", i, o_err, o_code, o_cyc);
        end
      end else begin
        if (!(o_done && o_cyc == ack_at + 1 && o_be == model_be(f, a) && o_we == w &&
              o_addr == (a - (a % 4)) && o_wdata == model_wdata(f, d))) begin
          bad++; $display("FAIL rand_access i=%0d done=%0b cyc=%0d be=%b/%b we=%0b addr=%h wdata=%h/%h",
                          i, o_done, o_cyc, o_be, model_be(f, a), o_we, o_addr, o_wdata, model_wdata(f, d));
        end
        if (!w) exp_rdata = model_load(f, a, word);
      end
      total++;
      if (rdata !== exp_rdata) begin
        bad++; $display("FAIL rand_rdata i=%0d got=%h want=%h", i, rdata, exp_rdata);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lbu();
    test_lh();
    test_misaligned();
    test_store();
    test_reserved();
    test_timeout();
    test_busy_ignore();
    test_reset_mid_access();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
